edge_window_scheduler: RTL and testbench
========================================

Name: edge_window_scheduler

Overview:
- Frame-level controller for the Sobel gradient unit.
- Walks every 3x3 interior window of an IMG_W x IMG_H 8-bit image held in pixel SRAM and fetches the 9 pixels.
- Presents them on P0..P8, pulses start, and waits for the unit's ready.
- Writes the returned 8-bit magnitude to the result SRAM; output image is (IMG_W-2) x (IMG_H-2).

Parameters:
- IMG_W, 16, image width in pixels; must be >= 3.
- IMG_H, 16, image height in pixels; must be >= 3.
- ADDR_W, 16, pixel/result address width; must hold IMG_W*IMG_H-1.
- GRAD_TIMEOUT, 64, max cycles to wait for gradient ready before aborting.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-high
- i_frame_start  in  1  start one frame pass; sampled in IDLE only
- o_rd_req  out  1  pixel read request, held until i_rd_valid
- o_rd_addr  out  ADDR_W  pixel address, stable while o_rd_req high
- i_rd_valid  in  1  read data valid (one cycle, >=1 cycle after req)
- i_rd_data  in  8  pixel data
- o_p0..o_p8  out  8 each  window pixels, row-major (P0..P2 top row)
- o_gradient_start  out  1  one-cycle start pulse to gradient unit
- i_gradient_data_ready  in  1  gradient result valid
- i_processed_sum  in  8  gradient magnitude
- o_wr_en  out  1  one-cycle result write strobe; sink always accepts
- o_wr_addr  out  ADDR_W  result address = r*(IMG_W-2)+c
- o_wr_data  out  8  result byte
- o_busy  out  1  high in any state except IDLE
- o_frame_done  out  1  one-cycle pulse after last write
- o_error  out  1  sticky timeout flag; cleared by reset or next accepted i_frame_start

Behaviour:
- Reset (n_rst=1, async): state IDLE; r=c=k=0; all outputs 0, including o_p0..o_p8 and o_error.
- Window origin is (r,c), with r in 0..IMG_H-3 and c in 0..IMG_W-3. Pixel k (0..8) address = (r+k/3)*IMG_W + (c+k%3).
- States:
  - IDLE: if i_frame_start, clear o_error, r=c=k=0, go FETCH.
  - FETCH: drive o_rd_req=1 and o_rd_addr for pixel k.
    - On i_rd_valid, latch i_rd_data into P[k] and drop the req the following cycle.
    - If k<8, k++ and stay in FETCH (next req issued the cycle after valid). If k==8, go LAUNCH.
  - LAUNCH: o_gradient_start=1 for exactly one cycle; clear timeout counter; go WAIT_GRAD.
  - WAIT_GRAD: count cycles.
    - On i_gradient_data_ready, capture i_processed_sum and go WRITE.
    - If count reaches GRAD_TIMEOUT with no ready, set o_error and go IDLE (frame aborted, no o_frame_done).
  - WRITE: o_wr_en=1, o_wr_addr, o_wr_data for one cycle; go ADVANCE.
  - ADVANCE:
    - If c<IMG_W-3: c++.
    - Else if r<IMG_H-3: c=0, r++.
    - Else go DONE.
    - k reset per the feature below; go FETCH otherwise.
  - DONE: o_frame_done=1 for one cycle; go IDLE.
- o_p0..o_p8 are held stable from LAUNCH until the next window's first pixel is latched.
- i_frame_start while busy: ignored.
- i_gradient_data_ready outside WAIT_GRAD: ignored.
- i_rd_valid without an outstanding req: ignored.
- Reset mid-frame aborts immediately; no partial write or done pulse.

Optional Feature:
- Macro: WINDOW_REUSE_EN.
- Defined:
  - On horizontal steps (c++), ADVANCE shifts the window left: P0<=P1, P1<=P2, P3<=P4, P4<=P5, P6<=P7, P7<=P8.
  - FETCH then reads only k=2,5,8 (new right column).
  - On a row wrap or the first window, all 9 pixels are read.
- Undefined: every window fetches all 9 pixels (k=0..8).
- Written results are identical in both builds.

Decomposition:
- Package edge_pkg holds:
  - the state enum (IDLE, FETCH, LAUNCH, WAIT_GRAD, WRITE, ADVANCE, DONE);
  - PIX_W=8;
  - typedef pixel_t (logic [7:0]);
  - typedef window_t (pixel_t [8:0]).
- One sub-module, edge_addr_gen: owns r/c/k counters and the pixel/result address arithmetic. Takes step/wrap/reset controls from the FSM and returns last_col, last_row and last_k flags.

Test Plan:
- IMG_W=IMG_H=4, memory[i]=i, read latency 1, gradient model returns P4 after 3 cycles.
  - Writes: 4 writes, addr 0,1,2,3, data 5,6,9,10.
  - Reads: 36 reads (no reuse).
  - Done: one o_frame_done pulse.
- Same frame with WINDOW_REUSE_EN:
  - Reads: 24 reads total.
  - Second window reads only addresses 3,7,11.
  - Writes identical to the first scenario.
- Read latency 5 on every access: o_rd_req and o_rd_addr stay stable for 5 cycles per read. o_p0..o_p8 for window (0,0) = 0,1,2,4,5,6,8,9,10 at LAUNCH.
- Gradient model never asserts ready, GRAD_TIMEOUT=64: o_error=1 exactly 64 cycles after start pulse, return to IDLE, no o_wr_en, no o_frame_done.
- n_rst asserted during third window's FETCH:
  - All outputs 0 asynchronously.
  - After release, i_frame_start restarts at (0,0), write addr 0.
- i_frame_start pulsed again mid-frame: ignored; exactly 4 writes and one done for a 4x4 frame.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types for the Sobel edge-window scheduler.
//   state_t  : scheduler FSM states
//   pixel_t  : one 8-bit pixel
//   window_t : nine pixels of a 3x3 window, index k = 3*row + col
package edge_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [8:0]     window_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    WAIT_GRAD,
    WRITE,
    ADVANCE,
    DONE
  } state_t;

  localparam logic [3:0] LAST_K = 4'd8;

endpackage

// File: rtl/edge_window_scheduler_addr_gen.sv
// Window counters and address arithmetic for the edge-window scheduler.
// Owns the window origin (r,c) and the pixel index k inside the window.
//   clk, n_rst          : clock, asynchronous active-high reset
//   clr                 : restart at window (0,0), pixel 0
//   k_step              : advance to the next pixel of the current window
//   col_step            : move the window one column right
//   row_wrap            : move the window to column 0 of the next row
//   k                   : current pixel index (0..8)
//   pix_addr            : pixel SRAM address of pixel k
//   res_addr            : result SRAM address r*(IMG_W-2)+c
//   last_k/last_col/last_row : end-of-window / end-of-row / last-row flags
// Build option WINDOW_REUSE_EN: after a column step only the new right
// column (k = 2,5,8) is walked.
module edge_addr_gen
  import edge_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              k_step,
  input  logic              col_step,
  input  logic              row_wrap,
  output logic [3:0]        k,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] res_addr,
  output logic              last_k,
  output logic              last_col,
  output logic              last_row
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [1:0]    k_row;
  logic [1:0]    k_col;

`ifdef WINDOW_REUSE_EN
  // Set while the current window only needs its right column fetched.
  logic col_only;
`endif

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r <= '0;
      c <= '0;
      k <= '0;
`ifdef WINDOW_REUSE_EN
      col_only <= 1'b0;
`endif
    end else if (clr) begin
      r <= '0;
      c <= '0;
      k <= '0;
`ifdef WINDOW_REUSE_EN
      col_only <= 1'b0;
`endif
    end else if (col_step) begin
      c <= c + CW'(1);
`ifdef WINDOW_REUSE_EN
      k        <= 4'd2;
      col_only <= 1'b1;
`else
      k <= '0;
`endif
    end else if (row_wrap) begin
      c <= '0;
      r <= r + RW'(1);
      k <= '0;
`ifdef WINDOW_REUSE_EN
      col_only <= 1'b0;
`endif
    end else if (k_step) begin
`ifdef WINDOW_REUSE_EN
      k <= col_only ? k + 4'd3 : k + 4'd1;
`else
      k <= k + 4'd1;
`endif
    end
  end

  // Split k into its row/column offset inside the window.
  always_comb begin
    k_row = 2'd0;
    k_col = 2'd0;
    case (k)
      4'd0:    begin k_row = 2'd0; k_col = 2'd0; end
      4'd1:    begin k_row = 2'd0; k_col = 2'd1; end
      4'd2:    begin k_row = 2'd0; k_col = 2'd2; end
      4'd3:    begin k_row = 2'd1; k_col = 2'd0; end
      4'd4:    begin k_row = 2'd1; k_col = 2'd1; end
      4'd5:    begin k_row = 2'd1; k_col = 2'd2; end
      4'd6:    begin k_row = 2'd2; k_col = 2'd0; end
      4'd7:    begin k_row = 2'd2; k_col = 2'd1; end
      4'd8:    begin k_row = 2'd2; k_col = 2'd2; end
      default: begin k_row = 2'd0; k_col = 2'd0; end
    endcase
  end

  assign pix_addr = (ADDR_W'(r) + ADDR_W'(k_row)) * ADDR_W'(IMG_W)
                  + ADDR_W'(c) + ADDR_W'(k_col);
  assign res_addr = ADDR_W'(r) * ADDR_W'(IMG_W - 2) + ADDR_W'(c);

  assign last_k   = (k == LAST_K);
  assign last_col = (c == CW'(IMG_W - 3));
  assign last_row = (r == RW'(IMG_H - 3));

endmodule

// File: rtl/edge_window_scheduler.sv
// Frame controller for the Sobel gradient unit. Walks every interior 3x3
// window of an IMG_W x IMG_H image in pixel SRAM, fetches its nine pixels,
// starts the gradient unit, and writes the returned magnitude to the result
// SRAM at r*(IMG_W-2)+c.
//   clk, n_rst                  : clock, asynchronous active-high reset
//   i_frame_start               : start a frame (accepted in IDLE only)
//   o_rd_req/o_rd_addr          : pixel read request, held until i_rd_valid
//   i_rd_valid/i_rd_data        : pixel read return
//   o_p0..o_p8                  : window pixels, row-major
//   o_gradient_start            : one-cycle start to the gradient unit
//   i_gradient_data_ready       : gradient result valid
//   i_processed_sum             : gradient magnitude
//   o_wr_en/o_wr_addr/o_wr_data : one-cycle result write
//   o_busy                      : not IDLE
//   o_frame_done                : one-cycle pulse after the last write
//   o_error                     : sticky gradient timeout flag
// Build option WINDOW_REUSE_EN: horizontal steps shift the window left and
// fetch only the new right column; results are identical.
module edge_window_scheduler
  import edge_pkg::*;
#(
  parameter int IMG_W        = 16,
  parameter int IMG_H        = 16,
  parameter int ADDR_W       = 16,
  parameter int GRAD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_frame_start,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [7:0]        i_rd_data,
  output logic [7:0]        o_p0,
  output logic [7:0]        o_p1,
  output logic [7:0]        o_p2,
  output logic [7:0]        o_p3,
  output logic [7:0]        o_p4,
  output logic [7:0]        o_p5,
  output logic [7:0]        o_p6,
  output logic [7:0]        o_p7,
  output logic [7:0]        o_p8,
  output logic              o_gradient_start,
  input  logic              i_gradient_data_ready,
  input  logic [7:0]        i_processed_sum,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_error
);

  localparam int CNT_W = $clog2(GRAD_TIMEOUT);
  // The counter reads 0 in the first WAIT_GRAD cycle; aborting when it reads
  // GRAD_TIMEOUT-2 makes o_error visible GRAD_TIMEOUT cycles after the start
  // pulse.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAD_TIMEOUT - 2);

  state_t            state_q, state_d;
  logic              clr, k_step, col_step, row_wrap;
  logic              last_k, last_col, last_row;
  logic [3:0]        k;
  logic [ADDR_W-1:0] pix_addr, res_addr;
  logic [CNT_W-1:0]  cnt_q;
  window_t           win_p0;
  pixel_t            sum_p1;
  logic              err_q;
  logic              timeout;

`ifdef WINDOW_REUSE_EN
  function automatic window_t shift_left(input window_t w);
    window_t s;
    s = w;
    for (int row = 0; row < 3; row++) begin
      s[3*row]     = w[3*row + 1];
      s[3*row + 1] = w[3*row + 2];
    end
    return s;
  endfunction
`endif

  edge_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (clr),
    .k_step   (k_step),
    .col_step (col_step),
    .row_wrap (row_wrap),
    .k        (k),
    .pix_addr (pix_addr),
    .res_addr (res_addr),
    .last_k   (last_k),
    .last_col (last_col),
    .last_row (last_row)
  );

  assign timeout = (state_q == WAIT_GRAD) && !i_gradient_data_ready
                && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    k_step   = 1'b0;
    col_step = 1'b0;
    row_wrap = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          clr     = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (i_rd_valid) begin
          if (last_k) state_d = LAUNCH;
          else        k_step  = 1'b1;
        end
      end
      LAUNCH:    state_d = WAIT_GRAD;
      WAIT_GRAD: begin
        if (i_gradient_data_ready) state_d = WRITE;
        else if (timeout)          state_d = IDLE;
      end
      WRITE:     state_d = ADVANCE;
      ADVANCE: begin
        if (!last_col) begin
          col_step = 1'b1;
          state_d  = FETCH;
        end else if (!last_row) begin
          row_wrap = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d = DONE;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Fetch stage: window capture; on reuse builds a column step shifts left
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      win_p0 <= '0;
    end else if (state_q == FETCH && i_rd_valid) begin
      win_p0[k] <= i_rd_data;
    end
`ifdef WINDOW_REUSE_EN
    else if (col_step) begin
      win_p0 <= shift_left(win_p0);
    end
`endif
  end

  // Gradient stage: timeout counter, result capture, sticky error
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      cnt_q  <= '0;
      sum_p1 <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == LAUNCH)         cnt_q <= '0;
      else if (state_q == WAIT_GRAD) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == WAIT_GRAD && i_gradient_data_ready) sum_p1 <= i_processed_sum;
      if (state_q == IDLE && i_frame_start) err_q <= 1'b0;
      else if (timeout)                     err_q <= 1'b1;
    end
  end

  // Output stage
  assign o_rd_req         = (state_q == FETCH);
  assign o_rd_addr        = o_rd_req ? pix_addr : '0;
  assign o_gradient_start = (state_q == LAUNCH);
  assign o_wr_en          = (state_q == WRITE);
  assign o_wr_addr        = o_wr_en ? res_addr : '0;
  assign o_wr_data        = o_wr_en ? sum_p1 : '0;
  assign o_busy           = (state_q != IDLE);
  assign o_frame_done     = (state_q == DONE);
  assign o_error          = err_q;

  assign o_p0 = win_p0[0];
  assign o_p1 = win_p0[1];
  assign o_p2 = win_p0[2];
  assign o_p3 = win_p0[3];
  assign o_p4 = win_p0[4];
  assign o_p5 = win_p0[5];
  assign o_p6 = win_p0[6];
  assign o_p7 = win_p0[7];
  assign o_p8 = win_p0[8];

endmodule

// File: tb/tb_edge_window_scheduler.sv
// Self-checking bench for edge_window_scheduler on a 4x4 image.
// Reference model derives expected reads, windows and writes from the image
// contents with plain arithmetic; memory and gradient responders emulate the
// SRAM and the gradient unit.
module tb_edge_window_scheduler;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 16;
  localparam int TO   = 64;
  localparam int NWIN = (W - 2) * (H - 2);
`ifdef WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam int READS = REUSE ? (H - 2) * (9 + (W - 3) * 3) : NWIN * 9;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_frame_start;
  logic          o_rd_req;
  logic [AW-1:0] o_rd_addr;
  logic          i_rd_valid;
  logic [7:0]    i_rd_data;
  logic [7:0]    o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8;
  logic          o_gradient_start;
  logic          i_gradient_data_ready;
  logic [7:0]    i_processed_sum;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_wr_data;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_error;

  always #5 clk = ~clk;

  edge_window_scheduler #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .GRAD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_frame_start(i_frame_start),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_p0(o_p0), .o_p1(o_p1), .o_p2(o_p2), .o_p3(o_p3), .o_p4(o_p4),
    .o_p5(o_p5), .o_p6(o_p6), .o_p7(o_p7), .o_p8(o_p8),
    .o_gradient_start(o_gradient_start),
    .i_gradient_data_ready(i_gradient_data_ready),
    .i_processed_sum(i_processed_sum),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_error(o_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Environment configuration
  logic [7:0] mem [W*H];
  int lat_fixed     = 1;   // 0 = random 1..4 per read
  int g_delay_fixed = 3;   // 0 = random 1..6 per window
  int g_mode        = 0;   // 0 = return P4, 1 = weighted sum, 2 = never ready
  bit mid_pulse     = 1'b0;

  // Logs and model expectations
  logic [AW-1:0] rd_log[$];
  logic [23:0]   wr_log[$];
  logic [71:0]   win_log[$];
  logic [AW-1:0] exp_rd[$];
  logic [23:0]   exp_wr[$];
  logic [71:0]   exp_win[$];
  int done_cnt  = 0;
  int hold_bad  = 0;
  int launch_idx = 0;

  function automatic logic [7:0] gval(input logic [71:0] w, input int mode);
    logic [7:0] s;
    s = 8'd0;
    if (mode == 0) return w[39:32];
    for (int i = 0; i < 9; i++) s = s + 8'(w[i*8 +: 8] * (i + 1));
    return s;
  endfunction

  task automatic build_model();
    logic [71:0] w;
    int a;
    exp_rd.delete(); exp_wr.delete(); exp_win.delete();
    for (int r = 0; r <= H - 3; r++) begin
      for (int c = 0; c <= W - 3; c++) begin
        for (int i = 0; i < 9; i++) begin
          a = (r + i / 3) * W + c + i % 3;
          w[i*8 +: 8] = mem[a];
          if (!REUSE || c == 0 || i % 3 == 2) exp_rd.push_back(AW'(a));
        end
        exp_win.push_back(w);
        exp_wr.push_back({16'(r * (W - 2) + c), gval(w, g_mode)});
      end
    end
  endtask

  // Pixel SRAM responder
  bit            rd_pending = 1'b0;
  int            rd_left    = 0;
  logic [AW-1:0] rd_addr_cur;
  initial begin
    i_rd_valid = 1'b0;
    i_rd_data  = 8'd0;
    forever begin
      @(negedge clk);
      i_rd_valid = 1'b0;
      if (n_rst) begin
        rd_pending = 1'b0;
      end else if (rd_pending) begin
        if (!o_rd_req || o_rd_addr !== rd_addr_cur) hold_bad++;
        rd_left--;
        if (rd_left == 0) begin
          i_rd_valid = 1'b1;
          i_rd_data  = mem[rd_addr_cur];
          rd_pending = 1'b0;
        end
      end else if (o_rd_req) begin
        rd_pending  = 1'b1;
        rd_addr_cur = o_rd_addr;
        rd_log.push_back(o_rd_addr);
        rd_left = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
      end else if ($urandom_range(0, 7) == 0) begin
        i_rd_valid = 1'b1;            // stray valid, no request outstanding
        i_rd_data  = 8'($urandom);
      end
    end
  end

  // Gradient unit responder
  bit         g_pending = 1'b0;
  int         g_left    = 0;
  logic [7:0] g_val;
  initial begin
    logic [71:0] obs;
    i_gradient_data_ready = 1'b0;
    i_processed_sum       = 8'd0;
    forever begin
      @(negedge clk);
      i_gradient_data_ready = 1'b0;
      if (n_rst) begin
        g_pending = 1'b0;
      end else if (g_pending) begin
        g_left--;
        if (g_left == 0) begin
          i_gradient_data_ready = 1'b1;
          i_processed_sum       = g_val;
          g_pending             = 1'b0;
        end
      end else if (o_gradient_start) begin
        obs = {o_p8, o_p7, o_p6, o_p5, o_p4, o_p3, o_p2, o_p1, o_p0};
        win_log.push_back(obs);
        if (launch_idx < exp_win.size()) chk("window", obs, exp_win[launch_idx]);
        else chk("window_extra", launch_idx, exp_win.size());
        launch_idx++;
        if (g_mode != 2) begin
          g_val     = gval(obs, g_mode);
          g_left    = (g_delay_fixed != 0) ? g_delay_fixed : $urandom_range(1, 6);
          g_pending = 1'b1;
        end
      end else if (g_mode != 2 && $urandom_range(0, 7) == 0) begin
        i_gradient_data_ready = 1'b1;  // stray ready outside WAIT_GRAD
        i_processed_sum       = 8'($urandom);
      end
    end
  end

  // Write / done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        if (o_wr_en) wr_log.push_back({o_wr_addr, o_wr_data});
        if (o_frame_done) done_cnt++;
      end
    end
  end

  task automatic start_frame();
    build_model();
    rd_log.delete(); wr_log.delete(); win_log.delete();
    done_cnt = 0; hold_bad = 0; launch_idx = 0;
    @(negedge clk);
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
    chk("err_clear_on_start", o_error, 1'b0);
    chk("busy_after_start", o_busy, 1'b1);
  endtask

  task automatic run_frame(input string tag);
    start_frame();
    for (int cyc = 0; cyc < 4000 && o_busy; cyc++) begin
      i_frame_start = mid_pulse && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    i_frame_start = 1'b0;
    chk({tag, "_frame_end"}, o_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk({tag, "_rd_count"}, rd_log.size(), READS);
    if (rd_log.size() == exp_rd.size())
      foreach (exp_rd[i]) chk($sformatf("%s_rd_addr%0d", tag, i), rd_log[i], exp_rd[i]);
    chk({tag, "_wr_count"}, wr_log.size(), NWIN);
    if (wr_log.size() == exp_wr.size())
      foreach (exp_wr[i]) chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
    chk({tag, "_launches"}, launch_idx, NWIN);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_rd_hold"}, hold_bad, 0);
    chk({tag, "_error"}, o_error, 1'b0);
  endtask

  initial begin
    int n;
    bit hit;
    logic [23:0] a_exp [4];
    n_rst         = 1'b1;
    i_frame_start = 1'b0;
    for (int i = 0; i < W * H; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_rd_req", o_rd_req, 1'b0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_pixels", {o_p8, o_p7, o_p6, o_p5, o_p4, o_p3, o_p2, o_p1, o_p0}, 72'd0);
    chk("rst_grad_start", o_gradient_start, 1'b0);
    chk("rst_wr", {o_wr_en, o_wr_addr, o_wr_data}, 0);
    chk("rst_done", o_frame_done, 1'b0);
    chk("rst_error", o_error, 1'b0);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Identity image, latency 1, gradient returns P4 after 3 cycles
    lat_fixed = 1; g_delay_fixed = 3; g_mode = 0; mid_pulse = 1'b0;
    run_frame("A");
    a_exp[0] = {16'd0, 8'd5}; a_exp[1] = {16'd1, 8'd6};
    a_exp[2] = {16'd2, 8'd9}; a_exp[3] = {16'd3, 8'd10};
    if (wr_log.size() == 4) foreach (a_exp[i]) chk($sformatf("A_const_wr%0d", i), wr_log[i], a_exp[i]);
    else chk("A_const_wr_n", wr_log.size(), 4);
`ifdef WINDOW_REUSE_EN
    if (rd_log.size() >= 12) begin
      chk("A_win1_rd0", rd_log[9],  3);
      chk("A_win1_rd1", rd_log[10], 7);
      chk("A_win1_rd2", rd_log[11], 11);
    end else chk("A_win1_rd_n", rd_log.size(), 12);
`endif

    // Latency 5 on every read
    lat_fixed = 5;
    run_frame("B");
    if (win_log.size() > 0)
      chk("B_win00", win_log[0], {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
    else chk("B_win00_n", win_log.size(), 1);

    // Gradient never ready: timeout abort
    lat_fixed = 1; g_mode = 2;
    start_frame();
    hit = 1'b0;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      if (o_gradient_start) hit = 1'b1;
      else @(negedge clk);
    end
    chk("T_start_seen", o_gradient_start, 1'b1);
    n = 0;
    for (int cyc = 0; cyc < 200 && !o_error; cyc++) begin
      @(negedge clk);
      n++;
    end
    chk("T_timeout_cycles", n, TO);
    chk("T_busy", o_busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("T_no_write", wr_log.size(), 0);
    chk("T_no_done", done_cnt, 0);
    chk("T_error_sticky", o_error, 1'b1);

    // Next accepted start clears the error
    g_mode = 0;
    run_frame("C");

    // Reset during the third window's fetch
    g_mode = 1; lat_fixed = 2; g_delay_fixed = 2;
    for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
    start_frame();
    hit = 1'b0;
    for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
      @(negedge clk);
      if (wr_log.size() == 2 && o_rd_req) hit = 1'b1;
    end
    chk("R_third_fetch", wr_log.size(), 2);
    @(negedge clk);
    #1 n_rst = 1'b1;
    #1;
    chk("R_async_busy", o_busy, 1'b0);
    chk("R_async_req", {o_rd_req, o_rd_addr}, 0);
    chk("R_async_pixels", {o_p8, o_p7, o_p6, o_p5, o_p4, o_p3, o_p2, o_p1, o_p0}, 72'd0);
    chk("R_async_misc", {o_gradient_start, o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_error}, 0);
    @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("R_no_done", done_cnt, 0);
    run_frame("R");
    if (wr_log.size() > 0) chk("R_first_wr_addr", wr_log[0][23:8], 0);
    else chk("R_first_wr_n", wr_log.size(), NWIN);

    // Randomized frames with random latencies and stray start pulses
    lat_fixed = 0; g_delay_fixed = 0; g_mode = 1; mid_pulse = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

endmodule
